// File: rtl/axis_pfb_chsel_4x64.sv
// Channel selector for the 4x64 analysis PFB output stream: tracks frame alignment
// from tlast and emits one programmable channel per frame as a single-sample AXIS stream.
module axis_pfb_chsel_4x64 #(
  parameter int N = 64,
  parameter int L = 8,
  parameter int B = 32
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 s_axis_tvalid,
  input  logic                 s_axis_tlast,
  input  logic [L*B-1:0]       s_axis_tdata,
  input  logic [$clog2(N)-1:0] CHSEL_REG,
  input  logic                 CLR_REG,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tvalid,
  output logic [B-1:0]         m_axis_tdata,
  output logic                 m_axis_tlast,
  output logic                 sync_err,
  output logic                 ovf
);

  localparam int SW = $clog2(N);
  localparam int LW = $clog2(L);
  localparam int CW = SW - LW;
  localparam logic [CW-1:0] CNT_MAX = CW'(N / L - 1);

  typedef enum logic {SYNC, LOCK} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [SW-1:0] chsel_r, chsel_nx;
  logic [SW-1:0] sel;
  logic [B-1:0]  lane_data;
  logic          cap;
  logic          serr_set;
  logic          ovf_set;
  logic          hs;

  // The latched select only governs beats after the first; beat 0 uses the live register.
  assign sel = (cnt == '0) ? CHSEL_REG : chsel_r;

  always_comb begin
    lane_data = '0;
    for (int k = 0; k < L; k++) begin
      if (sel[LW-1:0] == LW'(k)) lane_data = s_axis_tdata[k*B +: B];
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    chsel_nx = chsel_r;
    cap      = 1'b0;
    serr_set = 1'b0;
    if (s_axis_tvalid) begin
      case (state)
        SYNC: begin
          if (s_axis_tlast) begin
            state_nx = LOCK;
            cnt_nx   = '0;
          end
        end
        LOCK: begin
          if (cnt == '0) chsel_nx = CHSEL_REG;
          if (cnt == sel[SW-1:LW]) cap = 1'b1;
          if (s_axis_tlast) begin
            if (cnt != CNT_MAX) serr_set = 1'b1;
            cnt_nx = '0;
          end else if (cnt == CNT_MAX) begin
            serr_set = 1'b1;
            state_nx = SYNC;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: state_nx = SYNC;
      endcase
    end
  end

  assign hs      = m_axis_tvalid & m_axis_tready;
  assign ovf_set = cap & m_axis_tvalid & ~m_axis_tready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= SYNC;
      cnt     <= '0;
      chsel_r <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      chsel_r <= chsel_nx;
    end
  end

  // Single-entry output register: a new capture always replaces an unaccepted sample.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
    end else if (cap) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= lane_data;
    end else if (hs) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sync_err <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (serr_set)     sync_err <= 1'b1;
      else if (CLR_REG) sync_err <= 1'b0;
      if (ovf_set)      ovf <= 1'b1;
      else if (CLR_REG) ovf <= 1'b0;
    end
  end

  assign m_axis_tlast = 1'b1;

endmodule

// File: doc/axis_pfb_chsel_4x64.md
Name: axis_pfb_chsel_4x64

Overview:
- Consumer of the 4x64 analysis PFB output stream: 64 channels, 8 lanes x 32 bits per beat, 8 beats per frame, tlast on the final beat.
- Tracks frame alignment from tlast and extracts one programmable channel per frame.
- Presents the extracted channel as a single-sample AXIS stream with backpressure.
- Sits between the PFB output and per-channel downstream processing (DDS mixer, decimator, buffer).

Parameters:
- N, 64: channels per frame; power of 2.
- L, 8: lanes per input beat; power of 2, divides N.
- B, 32: sample width (16-bit I in the low half, 16-bit Q in the high half; passed through untouched).

Ports:
- aclk  in  1  clock for all logic.
- aresetn  in  1  reset; asynchronous, active-low.
- s_axis_tvalid  in  1  input beat valid. No tready: the input cannot be stalled.
- s_axis_tlast  in  1  last beat of a frame.
- s_axis_tdata  in  L*B  lane k occupies bits [k*B +: B] and carries channel beat*L+k.
- CHSEL_REG  in  log2(N)  selected channel; quasi-static, may change at any time.
- CLR_REG  in  1  level; while 1, clears the sticky status flags.
- m_axis_tready  in  1  downstream ready.
- m_axis_tvalid  out  1  output sample valid.
- m_axis_tdata  out  B  selected channel sample.
- m_axis_tlast  out  1  always 1; each sample is one frame.
- sync_err  out  1  sticky: frame length did not equal N/L beats.
- ovf  out  1  sticky: an unaccepted output sample was overwritten.

Behaviour:
- Reset (async assert, sync release):
  - state=SYNC, cnt=0, chsel_r=0.
  - m_axis_tvalid=0, m_axis_tdata=0, sync_err=0, ovf=0.
  - Reset mid-frame discards the partial frame and any pending output.
- Frame tracking; cnt is log2(N/L) bits, M=N/L-1 (7 by default). Only beats with s_axis_tvalid=1 are considered.
  - SYNC: ignore beats until a beat with tlast=1, then go to LOCK with cnt=0. No capture happens in SYNC.
  - LOCK, tlast=1: if cnt!=M, set sync_err. In all cases cnt<=0 and the state stays LOCK, realigning on tlast.
  - LOCK, tlast=0: if cnt==M, set sync_err and go to SYNC (frame too long); otherwise cnt<=cnt+1.
- Channel select:
  - On a LOCK beat with cnt==0, chsel_r<=CHSEL_REG.
  - Effective select is sel = (cnt==0) ? CHSEL_REG : chsel_r.
  - A CHSEL_REG change therefore takes effect only at a frame boundary; a frame never mixes two channels.
  - sel[log2(N)-1:log2(L)] gives the beat; sel[log2(L)-1:0] gives the lane.
- Capture: on a LOCK beat where cnt equals the beat field of sel, the selected lane is written to the output register.
  - The capture happens even if that beat later proves to be a sync error.
- Output register (single entry):
  - Latency: capture on cycle t gives m_axis_tvalid=1 with the data on cycle t+1.
  - Handshake: tvalid stays 1 and tdata stays stable until tvalid&tready.
  - Capture while the register is empty, or in the same cycle as a handshake: load, tvalid stays/becomes 1, no ovf.
  - Capture while tvalid=1 and tready=0: the new sample overwrites the old one, ovf<=1, and tvalid stays 1.
  - Handshake with no capture: tvalid<=0 next cycle.
- Status:
  - sync_err and ovf are sticky and cleared while CLR_REG=1.
  - If CLR_REG=1 and the error condition occur in the same cycle, the set wins.
- Gaps (tvalid=0) of any length within or between frames are legal; cnt holds during gaps.

Test Plan:
- Reset, then 3 well-formed frames with channel k at lane/beat carrying data 0x1000+k, CHSEL_REG=19, tready=1. Required: the first frame is discarded (SYNC), then two outputs of 0x1013 appear one cycle after beat 2 of each frame; sync_err=0 and ovf=0.
- CHSEL_REG=63 with tvalid asserted every 3rd cycle. Required: output 0x103F one cycle after beat 7 of each frame; cnt holds across gaps.
- CHSEL_REG switched from 5 to 60 at beat 4 of a frame. Required: that frame outputs channel 5; the next frame outputs channel 60.
- Frame of 6 beats with tlast on beat 5, then a normal frame. Required: sync_err=1 and the next frame is captured correctly. Frame of 9 beats. Required: sync_err=1, SYNC, and one frame is lost. CLR_REG pulse clears sync_err to 0.
- tready=0 for 3 frames with CHSEL_REG=0 and frames tagged 0xA, 0xB, 0xC. Required: ovf=1 and the held data equals 0xC after the third frame; tready=1 delivers exactly one sample.
- aresetn asserted mid-frame while m_axis_tvalid=1. Required: outputs go to 0 immediately and the block resyncs on the next tlast.
